// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then
// shifts a command byte out on device clock falls and collects the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_c_in,
    input  logic       ps2_d_in,
    output logic       ps2_c_pull,
    output logic       ps2_d_pull,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       idx_q, idx_d;
    logic             nack_q, nack_d;
    logic             c_pull_q, c_pull_d;
    logic             d_pull_q, d_pull_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       c_sync_q;
    logic [1:0]       d_sync_q;

    logic c_cur, d_cur, fall, to_state;

    // Synchronizers reset to the idle-high bus level so reset never produces a fall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_sync_q <= 3'b111;
            d_sync_q <= 2'b11;
        end else begin
            c_sync_q <= {c_sync_q[1:0], ps2_c_in};
            d_sync_q <= {d_sync_q[0], ps2_d_in};
        end
    end

    assign c_cur    = c_sync_q[1];
    assign d_cur    = d_sync_q[1];
    assign fall     = c_sync_q[2] & ~c_sync_q[1];
    assign to_state = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_REL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            nack_q   <= 1'b0;
            c_pull_q <= 1'b0;
            d_pull_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            nack_q   <= nack_d;
            c_pull_q <= c_pull_d;
            d_pull_q <= d_pull_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        nack_d   = nack_q;
        c_pull_d = c_pull_q;
        d_pull_d = d_pull_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Device-clock watchdog: restarts on every fall
        if (to_state) begin
            cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d  = {1'b1, ~^tx_data, tx_data};
                    c_pull_d = 1'b1;
                    d_pull_d = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    nack_d   = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    d_pull_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RTS: begin
                c_pull_d = 1'b0;
                idx_d    = '0;
                cnt_d    = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (fall) begin
                    d_pull_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[9:1]};
                    idx_d    = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = d_cur;
                    state_d = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (c_cur && d_cur) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                c_pull_d = 1'b0;
                d_pull_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // Abort wins over any same-cycle completion
        if (to_state && !fall && (cnt_q == TO_LAST)) begin
            c_pull_d = 1'b0;
            d_pull_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign ps2_c_pull = c_pull_q;
    assign ps2_d_pull = d_pull_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule
